// File: rtl/abs_peak_v3.sv
// Multi-channel ADC absolute-value stage with a windowed per-channel peak-hold.
// Two-stage pipeline (register, then abs) followed by peak tracking on valid_o samples.
module abs_peak_v3 #(
   parameter int unsigned data_width = 16,
   parameter int unsigned n_channels = 2,
   parameter int unsigned win_log2   = 10
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [n_channels*data_width-1:0] adc_data_i,
   input  logic                             valid_i,
   input  logic                             signed_i,
   input  logic                             clear_i,
   output logic [n_channels*data_width-1:0] adc_data_o,
   output logic [n_channels*data_width-1:0] abs_o,
   output logic                             valid_o,
   output logic [n_channels*data_width-1:0] peak_o,
   output logic                             peak_valid_o
);

   localparam int unsigned BusW = n_channels * data_width;
   localparam logic [data_width-1:0] MinNeg = {1'b1, {(data_width-1){1'b0}}};
   localparam logic [data_width-1:0] MaxPos = {1'b0, {(data_width-1){1'b1}}};
   localparam logic [data_width-1:0] One    = {{(data_width-1){1'b0}}, 1'b1};
   localparam logic [win_log2-1:0]   CntOne = {{(win_log2-1){1'b0}}, 1'b1};

   logic [BusW-1:0]     s1_data_q;
   logic                s1_valid_q;
   logic                s1_signed_q;
   logic [BusW-1:0]     data_q;
   logic [BusW-1:0]     abs_q;
   logic                valid_q;
   logic [BusW-1:0]     peak_q;
   logic                peak_valid_q;
   logic [BusW-1:0]     run_q;
   logic [win_log2-1:0] cnt_q;

   logic [BusW-1:0]     abs_d;
   logic [BusW-1:0]     max_d;

   // Sign and magnitude both come from the same stage-1 sample.
   always_comb begin
      abs_d = '0;
      for (int k = 0; k < int'(n_channels); k++) begin
         logic [data_width-1:0] smp;
         smp = s1_data_q[k*data_width +: data_width];
         if (s1_signed_q && smp[data_width-1]) begin
            if (smp == MinNeg) begin
               abs_d[k*data_width +: data_width] = MaxPos;
            end else begin
               abs_d[k*data_width +: data_width] = ~smp + One;
            end
         end else begin
            abs_d[k*data_width +: data_width] = smp;
         end
      end
   end

   always_comb begin
      max_d = run_q;
      for (int k = 0; k < int'(n_channels); k++) begin
         if (abs_q[k*data_width +: data_width] > run_q[k*data_width +: data_width]) begin
            max_d[k*data_width +: data_width] = abs_q[k*data_width +: data_width];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_data_q    <= '0;
         s1_valid_q   <= 1'b0;
         s1_signed_q  <= 1'b0;
         data_q       <= '0;
         abs_q        <= '0;
         valid_q      <= 1'b0;
         peak_q       <= '0;
         peak_valid_q <= 1'b0;
         run_q        <= '0;
         cnt_q        <= '0;
      end else begin
         s1_data_q    <= adc_data_i;
         s1_valid_q   <= valid_i;
         s1_signed_q  <= signed_i;
         data_q       <= s1_data_q;
         abs_q        <= abs_d;
         valid_q      <= s1_valid_q;
         peak_valid_q <= 1'b0;
         // Clear outranks both normal accumulation and a window-end sample.
         if (clear_i) begin
            run_q <= '0;
            cnt_q <= '0;
         end else if (valid_q) begin
            if (cnt_q == {win_log2{1'b1}}) begin
               peak_q       <= max_d;
               peak_valid_q <= 1'b1;
               run_q        <= '0;
               cnt_q        <= '0;
            end else begin
               run_q <= max_d;
               cnt_q <= cnt_q + CntOne;
            end
         end
      end
   end

   assign adc_data_o   = data_q;
   assign abs_o        = abs_q;
   assign valid_o      = valid_q;
   assign peak_o       = peak_q;
   assign peak_valid_o = peak_valid_q;

endmodule

// File: tb/tb_abs_peak_v3.sv
// Bench for abs_peak_v3: abs vector table plus peak-window, clear and reset sequences,
// checked through an output scoreboard and a bench-side peak model.
module tb_abs_peak_v3;

   localparam int Dw  = 16;
   localparam int Nch = 2;
   localparam int Wl2 = 2;
   localparam int Win = 4;

   logic              clk;
   logic              rst;
   logic [Nch*Dw-1:0] adc_data_i;
   logic              valid_i;
   logic              signed_i;
   logic              clear_i;
   logic [Nch*Dw-1:0] adc_data_o;
   logic [Nch*Dw-1:0] abs_o;
   logic              valid_o;
   logic [Nch*Dw-1:0] peak_o;
   logic              peak_valid_o;

   abs_peak_v3 #(
      .data_width(Dw),
      .n_channels(Nch),
      .win_log2  (Wl2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .adc_data_i  (adc_data_i),
      .valid_i     (valid_i),
      .signed_i    (signed_i),
      .clear_i     (clear_i),
      .adc_data_o  (adc_data_o),
      .abs_o       (abs_o),
      .valid_o     (valid_o),
      .peak_o      (peak_o),
      .peak_valid_o(peak_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d0;
      logic [15:0] d1;
      logic        sgn;
      logic [15:0] e0;
      logic [15:0] e1;
   } vec_t;

   typedef struct {
      bit          v;
      logic [15:0] a0;
      logic [15:0] a1;
   } stg_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          pulses = 0;
   logic [63:0] exp_q[$];
   logic [31:0] pk_q[$];
   logic [31:0] peak_now = '0;
   stg_t        p1, p2;
   logic [15:0] run0, run1;
   int          cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      p1 = '{v: 1'b0, a0: '0, a1: '0};
      p2 = '{v: 1'b0, a0: '0, a1: '0};
      run0 = '0;
      run1 = '0;
      cnt = 0;
      exp_q.delete();
      pk_q.delete();
      peak_now = '0;
      pulses = 0;
   endtask

   // Drive one cycle; e0/e1 are the expected abs values for this sample.
   task automatic drive(input logic [15:0] d0, input logic [15:0] d1, input logic v,
                        input logic s, input logic clr, input logic [15:0] e0,
                        input logic [15:0] e1);
      logic [15:0] m0, m1;
      adc_data_i = {d1, d0};
      valid_i    = v;
      signed_i   = s;
      clear_i    = clr;
      if (v) exp_q.push_back({e1, e0, d1, d0});
      if (clr) begin
         run0 = '0;
         run1 = '0;
         cnt  = 0;
      end else if (p2.v) begin
         m0 = (p2.a0 > run0) ? p2.a0 : run0;
         m1 = (p2.a1 > run1) ? p2.a1 : run1;
         if (cnt == Win - 1) begin
            pk_q.push_back({m1, m0});
            run0 = '0;
            run1 = '0;
            cnt  = 0;
         end else begin
            run0 = m0;
            run1 = m1;
            cnt++;
         end
      end
      p2 = p1;
      p1 = '{v: v, a0: e0, a1: e1};
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic pk(input logic [15:0] a0, input logic [15:0] a1, input logic v);
      drive(a0, a1, v, 1'b0, 1'b0, a0, a1);
   endtask

   // Asynchronous reset asserted and released between clock edges.
   task automatic async_reset();
      #2;
      rst     = 1'b1;
      valid_i = 1'b0;
      clear_i = 1'b0;
      #1;
      check("reset_outputs_zero", {adc_data_o, abs_o, peak_o, 6'b0, valid_o, peak_valid_o},
            64'h0);
      check("reset_data_zero", {32'h0, adc_data_o}, 64'h0);
      model_reset();
      #3;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid_o", {32'h0, abs_o}, 64'hDEAD);
         end else begin
            check("abs_and_data", {abs_o, adc_data_o}, exp_q.pop_front());
         end
      end
      if (peak_valid_o) begin
         pulses++;
         if (pk_q.size() == 0) begin
            check("unexpected_peak_pulse", {32'h0, peak_o}, 64'hDEAD);
         end else begin
            peak_now = pk_q.pop_front();
         end
      end
      check("peak_o_value", {32'h0, peak_o}, {32'h0, peak_now});
   end

   vec_t tbl[8];

   initial begin
      tbl[0] = '{d0: 16'hFFFE, d1: 16'h0005, sgn: 1'b1, e0: 16'h0002, e1: 16'h0005};
      tbl[1] = '{d0: 16'h8000, d1: 16'h0000, sgn: 1'b1, e0: 16'h7FFF, e1: 16'h0000};
      tbl[2] = '{d0: 16'h8000, d1: 16'h8001, sgn: 1'b0, e0: 16'h8000, e1: 16'h8001};
      tbl[3] = '{d0: 16'h7FFF, d1: 16'h8001, sgn: 1'b1, e0: 16'h7FFF, e1: 16'h7FFF};
      tbl[4] = '{d0: 16'hFFFF, d1: 16'h0001, sgn: 1'b1, e0: 16'h0001, e1: 16'h0001};
      tbl[5] = '{d0: 16'h0000, d1: 16'hC000, sgn: 1'b1, e0: 16'h0000, e1: 16'h4000};
      tbl[6] = '{d0: 16'h1234, d1: 16'hFFFF, sgn: 1'b0, e0: 16'h1234, e1: 16'hFFFF};
      tbl[7] = '{d0: 16'h8001, d1: 16'h8000, sgn: 1'b1, e0: 16'h7FFF, e1: 16'h7FFF};

      rst        = 1'b1;
      adc_data_i = '0;
      valid_i    = 1'b0;
      signed_i   = 1'b0;
      clear_i    = 1'b0;
      model_reset();
      #12;
      check("por_outputs_zero", {adc_data_o, abs_o, peak_o, 6'b0, valid_o, peak_valid_o},
            64'h0);
      #5;
      rst = 1'b0;

      // Latency: not valid after one edge, valid after two.
      drive(16'hFFFE, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0005);
      check("latency_edge1_valid", {63'h0, valid_o}, 64'h0);
      idle(1);
      check("latency_edge2_valid", {63'h0, valid_o}, 64'h1);
      check("latency_abs", {32'h0, abs_o}, 64'h0005_0002);
      check("latency_echo", {32'h0, adc_data_o}, 64'h0005_FFFE);
      idle(2);

      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].d0, tbl[i].d1, 1'b1, tbl[i].sgn, 1'b0, tbl[i].e0, tbl[i].e1);
      end
      idle(4);

      // Peak window, contiguous valid.
      async_reset();
      pk(3, 10, 1); pk(9, 20, 1); pk(1, 30, 1); pk(4, 40, 1);
      pk(2, 1, 1);  pk(2, 1, 1);  pk(2, 1, 1);  pk(2, 1, 1);
      idle(4);
      check("window_pulses", pulses, 2);
      check("window_peak_final", {32'h0, peak_o}, 64'h0001_0002);

      // Same stream with gaps carrying data that must not count.
      async_reset();
      pk(3, 10, 1); pk(16'h7000, 16'h7000, 0); pk(9, 20, 1); pk(16'h7000, 16'h7000, 0);
      pk(1, 30, 1); pk(16'h7000, 16'h7000, 0); pk(4, 40, 1); pk(16'h7000, 16'h7000, 0);
      pk(2, 1, 1);  pk(16'h7000, 16'h7000, 0); pk(2, 1, 1);  pk(16'h7000, 16'h7000, 0);
      pk(2, 1, 1);  pk(16'h7000, 16'h7000, 0); pk(2, 1, 1);  pk(16'h7000, 16'h7000, 0);
      idle(4);
      check("gapped_pulses", pulses, 2);
      check("gapped_peak_final", {32'h0, peak_o}, 64'h0001_0002);

      // Clear mid-window, then clear on a window-end sample.
      async_reset();
      pk(9, 9, 1); pk(9, 9, 1); idle(1);
      drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
      pk(1, 5, 1); pk(2, 5, 1); pk(3, 5, 1); pk(2, 5, 1);
      idle(4);
      check("clear_restart_pulses", pulses, 1);
      check("clear_restart_peak", {32'h0, peak_o}, 64'h0005_0003);
      pk(5, 5, 1); pk(5, 5, 1); pk(5, 5, 1); pk(5, 5, 1);
      idle(1);
      drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
      idle(3);
      check("clear_window_end_pulses", pulses, 1);
      check("clear_window_end_peak", {32'h0, peak_o}, 64'h0005_0003);
      pk(7, 8, 1); pk(7, 8, 1); pk(7, 8, 1); pk(7, 8, 1);
      idle(4);
      check("after_clear_peak", {32'h0, peak_o}, 64'h0008_0007);

      // Reset three samples into a window.
      async_reset();
      pk(8, 8, 1); pk(8, 8, 1); pk(8, 8, 1);
      async_reset();
      pk(1, 2, 1); pk(1, 2, 1); pk(1, 2, 1); pk(6, 2, 1);
      idle(4);
      check("post_reset_pulses", pulses, 1);
      check("post_reset_peak", {32'h0, peak_o}, 64'h0002_0006);

      check("scoreboard_drained", exp_q.size(), 0);
      check("peak_queue_drained", pk_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
